// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared field widths, limits and display-word packing for the
//               minutes:seconds timekeeping block.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam int FIELD_W   = 6;
    localparam int FIELD_MAX = 59;
    localparam int PHASE_W   = 3;

    // Display word layout expected by the 7-segment driver: minutes on top
    function automatic logic [2*FIELD_W-1:0] pack_time(
        input logic [FIELD_W-1:0] min,
        input logic [FIELD_W-1:0] sec
    );
        return {min, sec};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod60_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod60_counter
// Description : One time field (0..59). Clear beats increment; wrap flags an
//               increment that rolls 59 over to 0 so the caller can carry.
// Revision    : 1.0 - initial release
// ============================================================================
module mod60_counter
    import clock_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [FIELD_W-1:0] value,
    output logic               wrap
);

    localparam logic [FIELD_W-1:0] c_MAX = FIELD_W'(FIELD_MAX);

    logic [FIELD_W-1:0] r_value;

    assign wrap  = inc && (r_value == c_MAX);
    assign value = r_value;

    // Field register: only ever loaded by zeroing or a single-step increment
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= wrap ? '0 : r_value + FIELD_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : clock_time_counter
// Description : 1 Hz prescaler, minutes:seconds timekeeping with manual
//               adjust, and the free-running digit-scan phase for the display
//               driver. Build macro ADJ_EDGE_EN turns the adjust inputs from
//               level-qualified into rising-edge-qualified requests.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int PRESCALE = 12000000,
    parameter int SCAN_DIV = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 clear,
    input  logic                 inc_min,
    input  logic                 inc_sec,
    output logic [2*FIELD_W-1:0] data_show,
    output logic [PHASE_W-1:0]   byte_status,
    output logic                 tick_1hz
);

    localparam int c_PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PS_W-1:0]   c_PS_LAST   = c_PS_W'(PRESCALE - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);

    logic [c_PS_W-1:0]   r_prescale;
    logic [c_SCAN_W-1:0] r_scan;
    logic [PHASE_W-1:0]  r_phase;
    logic                r_tick;

    logic               w_req_min;
    logic               w_req_sec;
    logic               w_any_adj;
    logic               w_ps_wrap;
    logic               w_tick;
    logic               w_sec_inc;
    logic               w_min_inc;
    logic               w_sec_wrap;
    logic               w_unused_min_wrap;
    logic [FIELD_W-1:0] w_seconds;
    logic [FIELD_W-1:0] w_minutes;

`ifdef ADJ_EDGE_EN
    logic r_inc_min_d;
    logic r_inc_sec_d;
    logic r_armed;

    // Edge-detect history; r_armed stays low for the first cycle after reset
    // so an input already held high at release is not taken as a new press
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_inc_min_d <= 1'b0;
            r_inc_sec_d <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_inc_min_d <= inc_min;
            r_inc_sec_d <= inc_sec;
            r_armed     <= 1'b1;
        end
    end

    assign w_req_min = r_armed & inc_min & ~r_inc_min_d;
    assign w_req_sec = r_armed & inc_sec & ~r_inc_sec_d;
`else
    assign w_req_min = inc_min;
    assign w_req_sec = inc_sec;
`endif

    // Priority clear > adjust > tick: an adjust swallows a coincident tick so
    // a field never moves by two in one cycle
    assign w_any_adj = w_req_min | w_req_sec;
    assign w_ps_wrap = run && (r_prescale == c_PS_LAST);
    assign w_tick    = w_ps_wrap & ~clear & ~w_any_adj;

    // Seconds carry into minutes only on a real tick, never on an adjust
    assign w_sec_inc = w_req_sec | w_tick;
    assign w_min_inc = w_req_min | (w_tick & w_sec_wrap);

    // Prescaler: zeroed by clear or any adjust, frozen while run is low
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prescale <= '0;
        end else if (clear || w_any_adj) begin
            r_prescale <= '0;
        end else if (run) begin
            r_prescale <= w_ps_wrap ? '0 : r_prescale + c_PS_W'(1);
        end
    end

    // Tick strobe lands with the updated time word
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
        end
    end

    // Digit-scan phase runs freely; only reset touches it
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_scan  <= '0;
            r_phase <= '0;
        end else if (r_scan == c_SCAN_LAST) begin
            r_scan  <= '0;
            r_phase <= r_phase + PHASE_W'(1);
        end else begin
            r_scan  <= r_scan + c_SCAN_W'(1);
        end
    end

    mod60_counter u_seconds (
        .clock (clock),
        .reset (reset),
        .clr   (clear),
        .inc   (w_sec_inc),
        .value (w_seconds),
        .wrap  (w_sec_wrap)
    );

    // Minutes roll 59 -> 0 with nothing above them, so their wrap is unused
    mod60_counter u_minutes (
        .clock (clock),
        .reset (reset),
        .clr   (clear),
        .inc   (w_min_inc),
        .value (w_minutes),
        .wrap  (w_unused_min_wrap)
    );

    assign data_show   = pack_time(w_minutes, w_seconds);
    assign byte_status = r_phase;
    assign tick_1hz    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_time_counter
// Description : Self-checking bench for clock_time_counter with directed
//               scenarios followed by random stimulus against a reference
//               model that keeps time as elapsed-second arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_time_counter;

    localparam int PRESCALE = 4;
    localparam int SCAN_DIV = 2;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic        run     = 1'b0;
    logic        clear   = 1'b0;
    logic        inc_min = 1'b0;
    logic        inc_sec = 1'b0;
    logic [11:0] data_show;
    logic [2:0]  byte_status;
    logic        tick_1hz;

    clock_time_counter #(
        .PRESCALE (PRESCALE),
        .SCAN_DIV (SCAN_DIV)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .clear       (clear),
        .inc_min     (inc_min),
        .inc_sec     (inc_sec),
        .data_show   (data_show),
        .byte_status (byte_status),
        .tick_1hz    (tick_1hz)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: time of day in seconds, prescaler phase, edges since
    // reset release (scan phase derives from it), expected tick strobe
    int m_time;
    int m_ps;
    int m_cyc;
    int m_tick;
    bit m_prev_min;
    bit m_prev_sec;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_word();
        return (m_time / 60) * 64 + (m_time % 60);
    endfunction

    // Advance the model by one rising edge using the inputs present at it
    task automatic model_edge();
        bit rq_min;
        bit rq_sec;
        int mm;
        int ss;
        if (!reset) begin
            m_time = 0;
            m_ps   = 0;
            m_cyc  = 0;
            m_tick = 0;
        end else begin
            m_cyc++;
            m_tick = 0;
`ifdef ADJ_EDGE_EN
            rq_min = inc_min && !m_prev_min && (m_cyc >= 2);
            rq_sec = inc_sec && !m_prev_sec && (m_cyc >= 2);
`else
            rq_min = inc_min;
            rq_sec = inc_sec;
`endif
            if (clear) begin
                m_time = 0;
                m_ps   = 0;
            end else if (rq_min || rq_sec) begin
                mm = m_time / 60;
                ss = m_time % 60;
                if (rq_min) mm = (mm + 1) % 60;
                if (rq_sec) ss = (ss + 1) % 60;
                m_time = mm * 60 + ss;
                m_ps   = 0;
            end else if (run) begin
                if (m_ps == PRESCALE - 1) begin
                    m_ps   = 0;
                    m_tick = 1;
                    m_time = (m_time + 1) % 3600;
                end else begin
                    m_ps++;
                end
            end
        end
        m_prev_min = inc_min;
        m_prev_sec = inc_sec;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_eq("data_show",   int'(data_show),   exp_word());
        check_eq("byte_status", int'(byte_status), (m_cyc / SCAN_DIV) % 8);
        check_eq("tick_1hz",    int'(tick_1hz),    m_tick);
    endtask

    // Load mm:ss through clear plus single adjust pulses (valid in both modes)
    task automatic set_time(input int mm, input int ss);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < mm; i++) begin
            inc_min = 1'b1; step();
            inc_min = 1'b0; step();
        end
        for (int i = 0; i < ss; i++) begin
            inc_sec = 1'b1; step();
            inc_sec = 1'b0; step();
        end
    endtask

    initial begin
        // Reset asserted mid-count, held 3 cycles, released with run high
        reset = 1'b0;
        step();
        reset = 1'b1;
        run   = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        check_eq("reset_show",  int'(data_show),   0);
        check_eq("reset_phase", int'(byte_status), 0);
        reset = 1'b1;
        repeat (3) step();
        check_eq("pre_first_tick", int'(tick_1hz), 0);
        step();
        check_eq("first_tick", int'(tick_1hz), 1);
        check_eq("first_sec",  int'(data_show), 12'h001);

        // 60 ticks from 00:00 carry into minutes
        repeat (59 * PRESCALE) step();
        check_eq("one_minute", int'(data_show), 12'h040);

        // 59:59 rolls over to 00:00 on the next tick
        run = 1'b0;
        set_time(59, 59);
        check_eq("preload_5959", int'(data_show), 59 * 64 + 59);
        run = 1'b1;
        repeat (PRESCALE) step();
        check_eq("rollover_show", int'(data_show), 0);
        check_eq("rollover_tick", int'(tick_1hz), 1);

        // Frozen time, scan phase keeps running through a 7->0 wrap
        run = 1'b0;
        repeat (20) step();
        check_eq("frozen_show", int'(data_show), 0);

        // Adjust coinciding with prescaler wrap wins over the tick
        set_time(0, 10);
        run = 1'b1;
        repeat (PRESCALE - 1) step();
        inc_sec = 1'b1;
        step();
        inc_sec = 1'b0;
        check_eq("adj_vs_tick_sec",  int'(data_show), 11);
        check_eq("adj_vs_tick_tick", int'(tick_1hz), 0);
        repeat (PRESCALE - 1) step();
        check_eq("post_adj_no_tick", int'(tick_1hz), 0);
        step();
        check_eq("post_adj_tick", int'(tick_1hz), 1);
        check_eq("post_adj_sec",  int'(data_show), 12);

        // Clear beats a simultaneous adjust
        run = 1'b0;
        set_time(12, 34);
        clear   = 1'b1;
        inc_min = 1'b1;
        step();
        clear   = 1'b0;
        inc_min = 1'b0;
        step();
        check_eq("clear_vs_adj", int'(data_show), 0);

        // Seconds adjust at 59 wraps without carrying into minutes
        set_time(5, 59);
        inc_sec = 1'b1;
        step();
        inc_sec = 1'b0;
        step();
        check_eq("adj_sec_nocarry", int'(data_show), 5 * 64);

        // Held minute adjust: one step per press or one per clock
        inc_min = 1'b1;
        repeat (5) step();
        inc_min = 1'b0;
        step();
`ifdef ADJ_EDGE_EN
        check_eq("held_inc_min", int'(data_show), 6 * 64);
`else
        check_eq("held_inc_min", int'(data_show), 10 * 64);
`endif

        // Random traffic across every input
        run = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            reset   = ($urandom_range(0, 299) != 0);
            run     = ($urandom_range(0, 9) < 8);
            clear   = ($urandom_range(0, 79) == 0);
            inc_min = ($urandom_range(0, 24) == 0);
            inc_sec = ($urandom_range(0, 14) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
